// File: rtl/cpu_pkg.sv
// Shared core-wide constants and helpers for the RV32 front end.
package cpu_pkg;
   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;
   localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
      return a & ~XLEN'(3);
   endfunction
endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage channels: redirect in, imem request/response, instruction out to decode.
interface ifetch_if;
   import cpu_pkg::*;

   logic                redirect_valid;
   logic [XLEN-1:0]     redirect_pc;
   logic                imem_req_valid;
   logic                imem_req_ready;
   logic [XLEN-1:0]     imem_req_addr;
   logic                imem_resp_valid;
   logic [INSTR_W-1:0]  imem_resp_data;
   logic                out_valid;
   logic                out_ready;
   logic [INSTR_W-1:0]  out_instr;
   logic [XLEN-1:0]     out_pc;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
      output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
      input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc
   );
endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous first-word-fall-through FIFO with a single-cycle flush.
module ifetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   // a pop frees the head slot in the same cycle, so push into a full FIFO is fine then
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, issues credit-limited imem reads, buffers responses for decode.
module ifetch
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 2
) (
   input logic      clk,
   input logic      rst_n,
   ifetch_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                      run;
   logic [XLEN-1:0]           pc;
   logic [CW-1:0]             kill;
   logic [CW-1:0]             inflight;
   logic [CW-1:0]             inflight_nxt;
   logic [CW-1:0]             buf_count;
   logic [XLEN-1:0]           tag_head;
   logic [XLEN+INSTR_W-1:0]   buf_head;
   logic                      tag_empty, tag_full, buf_empty, buf_full;
   logic                      fire, resp, keep, pop;

   // run keeps requests quiet while reset is held; credit itself only looks at registers
   assign bus.imem_req_valid = run && (({1'b0, inflight} + {1'b0, buf_count}) < (CW+1)'(DEPTH));
   assign bus.imem_req_addr  = pc;

   assign fire         = bus.imem_req_valid && bus.imem_req_ready;
   assign resp         = bus.imem_resp_valid;
   assign keep         = resp && (kill == '0);
   assign pop          = bus.out_valid && bus.out_ready;
   assign inflight_nxt = inflight + CW'(fire) - CW'(resp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run  <= 1'b0;
         pc   <= align_pc(RESET_PC);
         kill <= '0;
      end else begin
         run <= 1'b1;
         if (bus.redirect_valid) begin
            // everything still outstanding, including a request fired this cycle, is stale
            pc   <= align_pc(bus.redirect_pc);
            kill <= inflight_nxt;
         end else begin
            if (fire) pc <= pc + XLEN'(PC_STEP);
            if (resp && (kill != '0)) kill <= kill - CW'(1);
         end
      end
   end

   // tag queue occupancy is exactly the number of requests in flight
   ifetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (1'b0),
      .push      (fire),
      .push_data (pc),
      .pop       (resp),
      .pop_data  (tag_head),
      .count     (inflight),
      .empty     (tag_empty),
      .full      (tag_full)
   );

   ifetch_fifo #(.WIDTH(XLEN+INSTR_W), .DEPTH(DEPTH)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.redirect_valid),
      .push      (keep),
      .push_data ({tag_head, bus.imem_resp_data}),
      .pop       (pop),
      .pop_data  (buf_head),
      .count     (buf_count),
      .empty     (buf_empty),
      .full      (buf_full)
   );

   assign bus.out_valid = !buf_empty;
   assign bus.out_pc    = buf_head[XLEN+INSTR_W-1:INSTR_W];
   assign bus.out_instr = buf_head[INSTR_W-1:0];

   a_resp_buf_full: assert property (@(posedge clk) disable iff (!rst_n) !(resp && buf_full));
   a_resp_no_req:   assert property (@(posedge clk) disable iff (!rst_n) !(resp && tag_empty));
   a_fire_tag_full: assert property (@(posedge clk) disable iff (!rst_n) !(fire && tag_full));
endmodule
